cascade_sequencer: RTL and testbench
====================================

# cascade_sequencer

Clocked, parametrised cascade-bus sequencer for the interrupt controller. It replaces the combinational CAS compare with an INTA-pulse state machine. As master it drives the acknowledged slave ID onto the CAS bus for the whole acknowledge sequence. As slave it samples CAS on the second pulse and claims the vector. It supports 2-pulse (8086) and 3-pulse (8080) sequences, with a configurable CAS width and an optional inter-pulse timeout.

## Interface
- CAS_W, 3: CAS bus width; the device serves N_IR = 2**CAS_W request lines
- TO_CYCLES, 64: timeout limit in clocks, counted from the end of one pulse to the start of the next (used only with the timeout macro)
- CLK  in  1  clock; all state changes on the rising edge
- RST_N  in  1  reset, asynchronous, active-low
- SP_EN  in  1  1 = master, 0 = slave
- SNGL  in  1  single mode; cascade disabled
- MODE_8080  in  1  1 = 3-pulse sequence, 0 = 2-pulse sequence
- ICW3  in  N_IR  master: slave-present mask; slave: ID in ICW3[CAS_W-1:0]
- ACK_IR  in  CAS_W  IR index being acknowledged; valid at the first pulse start
- INTA  in  1  synchronised INTA level, 1 = pulse in progress
- CAS_IN  in  CAS_W  CAS bus sampled value
- CAS_OUT  out  CAS_W  CAS value driven by the master
- CAS_OE  out  1  CAS output enable
- SEL_SLAVE  out  1  slave addressed in the current sequence
- CODE_EN  out  1  this device drives the data bus during the current pulse
- BYTE_SEL  out  2  byte to drive: 0 = CALL opcode, 1 = vector / low address, 2 = high address
- BUSY  out  1  sequence in progress
- ERR  out  1  one-cycle pulse on timeout abort

## Operation
- Pulse edge detection:
  - INTA is registered into inta_q.
  - Start = INTA & !inta_q.
  - End = !INTA & inta_q.
  - A pulse counter PCNT (2 bits) counts starts.
- States:
  - IDLE → ACTIVE on a start; latch ACK_IR and set PCNT = 1.
  - ACTIVE: each start increments PCNT.
  - The end of the last pulse (pulse 2, or pulse 3 when MODE_8080) → IDLE, with all outputs cleared.
  - Timeout → ABORT (one cycle, ERR = 1) → IDLE.
- Cascaded master: SP_EN=1 & !SNGL & ICW3[ACK_IR]=1.
  - CAS_OUT = ACK_IR and CAS_OE = 1 from the first start to the last end.
  - CODE_EN = 1 only for pulse 1 in 8080 mode, with BYTE_SEL = 0.
- Non-cascaded master (bit clear, or SNGL):
  - CAS_OE = 0.
  - The master sources all bytes: CODE_EN = 1 during pulse 2 (BYTE_SEL = 1), during pulse 3 (BYTE_SEL = 2), and during pulse 1 in 8080 mode (BYTE_SEL = 0).
- Slave (SP_EN=0, !SNGL):
  - Never drives CAS.
  - On the pulse-2 start, compares CAS_IN with ICW3[CAS_W-1:0]; a match sets SEL_SLAVE = 1 until IDLE.
  - A selected slave asserts CODE_EN during pulses 2 and 3.
  - A slave in SNGL behaves as a non-cascaded master.
- CODE_EN is high only between a start and the next end. It is never high between pulses.
- Simultaneous events:
  - A start in the same cycle as the ABORT→IDLE transition is treated as a new first pulse.
  - ICW3, SP_EN, MODE_8080 and SNGL are sampled at the first start and held for the sequence. Mid-sequence changes are ignored.
  - ACK_IR ≥ N_IR cannot occur, by width.
- A 4th start in 8080 mode, or a 3rd start in 8086 mode, cannot occur, because IDLE is re-entered at the final end. Any such start begins a new sequence.

## Timing
- Reset (asynchronous, RST_N=0): state IDLE, PCNT = 0, inta_q = 0, all outputs 0 (CAS_OUT = 0, CAS_OE = 0, SEL_SLAVE = 0, CODE_EN = 0, BYTE_SEL = 0, BUSY = 0, ERR = 0).
- Reset mid-sequence aborts immediately, with no ERR.
- All outputs are registered.
- Edge detection adds 1 cycle: INTA rises before edge t, is sampled at edge t, and outputs change after edge t+1.
- CAS_OE rises one cycle after the first start is detected and falls one cycle after the final end is detected.
- SEL_SLAVE becomes valid one cycle after the pulse-2 start. CAS_IN must be stable when that start is sampled.
- BUSY is high from the cycle after the first start until the cycle after the final end.

## Configuration
- CASCADE_TIMEOUT_EN defined:
  - A counter of width $clog2(TO_CYCLES+1) runs in ACTIVE while INTA = 0 and clears on each start.
  - Reaching TO_CYCLES forces ABORT, a one-cycle ERR pulse, and a return to IDLE with outputs cleared.
- CASCADE_TIMEOUT_EN undefined:
  - No counter; ERR is tied to 0.
  - The sequence waits indefinitely for the next pulse.

## Test plan
- Master, CAS_W = 3, ICW3 = 8'h09, ACK_IR = 3, 8086 mode, two pulses:
  - CAS_OUT = 3 and CAS_OE = 1 throughout the sequence.
  - CODE_EN = 0 on both pulses.
  - CAS_OE drops one cycle after pulse 2 ends.
- Master, ICW3 = 8'h09, ACK_IR = 2:
  - CAS_OE = 0.
  - CODE_EN = 1 during pulse 2 with BYTE_SEL = 1.
- Two slaves with IDs 1 and 7, master driving CAS = 7:
  - Slave ID 7 shows SEL_SLAVE = 1 and CODE_EN during pulse 2.
  - Slave ID 1 stays 0.
- 8080 mode, master ICW3 = 8'h01, ACK_IR = 0, slave ID 0:
  - Master CODE_EN with BYTE_SEL = 0 on pulse 1.
  - Slave CODE_EN with BYTE_SEL = 1 on pulse 2 and BYTE_SEL = 2 on pulse 3.
  - BUSY falls after pulse 3.
- With CASCADE_TIMEOUT_EN and TO_CYCLES = 8, send pulse 1 then hold INTA low for 9 cycles:
  - ERR pulses once.
  - All outputs return to 0 and BUSY = 0.
- Drop RST_N during pulse 2 of an active master sequence:
  - CAS_OE, CODE_EN and BUSY go to 0 asynchronously.
  - The next INTA rise starts a fresh pulse 1.

Source files
------------

// File: rtl/cascade_sequencer.sv
// Cascade-bus sequencer: tracks INTA pulses, drives CAS as master, claims the vector as slave.
// Outputs are registered one cycle behind the edge detector; CASCADE_TIMEOUT_EN adds an inter-pulse abort.
module cascade_sequencer #(
    parameter int CAS_W     = 3,
    parameter int TO_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sp_en,
    input  logic                sngl,
    input  logic                mode_8080,
    input  logic [2**CAS_W-1:0] icw3,
    input  logic [CAS_W-1:0]    ack_ir,
    input  logic                inta,
    input  logic [CAS_W-1:0]    cas_in,
    output logic [CAS_W-1:0]    cas_out,
    output logic                cas_oe,
    output logic                sel_slave,
    output logic                code_en,
    output logic [1:0]          byte_sel,
    output logic                busy,
    output logic                err
);

    typedef enum logic [1:0] {IDLE, ACTIVE, ABORT} state_t;

    state_t           state, state_nx;
    logic             inta_q;
    logic [1:0]       pcnt, pcnt_nx;
    logic [CAS_W-1:0] ack_q, ack_nx, id_q, id_nx;
    logic             casc_q, casc_nx, src_q, src_nx, slv_q, slv_nx;
    logic             m8080_q, m8080_nx, sel_q, sel_nx;
    logic             start, fin, last, timeout;

    assign start = inta & ~inta_q;
    assign fin   = ~inta & inta_q;
    assign last  = fin && (pcnt == (m8080_q ? 2'd3 : 2'd2));

`ifdef CASCADE_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    // Counts idle-bus clocks between pulses; any high INTA sample restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt <= '0;
        else if (state != ACTIVE || inta)
            to_cnt <= '0;
        else if (to_cnt != TO_W'(TO_CYCLES))
            to_cnt <= to_cnt + 1'b1;
    end

    assign timeout = (state == ACTIVE) && !inta && (to_cnt == TO_W'(TO_CYCLES));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        pcnt_nx  = pcnt;
        ack_nx   = ack_q;
        id_nx    = id_q;
        casc_nx  = casc_q;
        src_nx   = src_q;
        slv_nx   = slv_q;
        m8080_nx = m8080_q;
        sel_nx   = sel_q;
        case (state)
            ACTIVE: begin
                if (start) begin
                    pcnt_nx = pcnt + 2'd1;
                    if (pcnt == 2'd1)
                        sel_nx = slv_q && (cas_in == id_q);
                end else if (last || timeout) begin
                    state_nx = last ? IDLE : ABORT;
                    pcnt_nx  = 2'd0;
                    sel_nx   = 1'b0;
                end
            end
            default: begin
                // ABORT lasts one cycle; a start seen here opens a fresh sequence.
                state_nx = IDLE;
                if (start) begin
                    state_nx = ACTIVE;
                    pcnt_nx  = 2'd1;
                    ack_nx   = ack_ir;
                    id_nx    = icw3[CAS_W-1:0];
                    m8080_nx = mode_8080;
                    casc_nx  = sp_en & ~sngl & icw3[ack_ir];
                    slv_nx   = ~sp_en & ~sngl;
                    src_nx   = ~(sp_en & ~sngl & icw3[ack_ir]) & ~(~sp_en & ~sngl);
                    sel_nx   = 1'b0;
                end
            end
        endcase
    end

    logic             active, in_pulse, drive, code_d;
    logic [1:0]       byte_d;
    logic [CAS_W-1:0] cas_d;

    always_comb begin
        active   = (state == ACTIVE);
        in_pulse = active & inta_q;
        if (casc_q)
            drive = m8080_q && (pcnt == 2'd1);
        else if (src_q)
            drive = m8080_q || (pcnt >= 2'd2);
        else
            drive = sel_q && (pcnt >= 2'd2);
        code_d = in_pulse & drive;
        byte_d = code_d ? 2'(pcnt - 2'd1) : 2'd0;
        cas_d  = (active && casc_q) ? ack_q : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            inta_q    <= 1'b0;
            pcnt      <= 2'd0;
            ack_q     <= '0;
            id_q      <= '0;
            casc_q    <= 1'b0;
            src_q     <= 1'b0;
            slv_q     <= 1'b0;
            m8080_q   <= 1'b0;
            sel_q     <= 1'b0;
            cas_out   <= '0;
            cas_oe    <= 1'b0;
            sel_slave <= 1'b0;
            code_en   <= 1'b0;
            byte_sel  <= 2'd0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            inta_q    <= inta;
            pcnt      <= pcnt_nx;
            ack_q     <= ack_nx;
            id_q      <= id_nx;
            casc_q    <= casc_nx;
            src_q     <= src_nx;
            slv_q     <= slv_nx;
            m8080_q   <= m8080_nx;
            sel_q     <= sel_nx;
            cas_out   <= cas_d;
            cas_oe    <= active & casc_q;
            sel_slave <= active & sel_q;
            code_en   <= code_d;
            byte_sel  <= byte_d;
            busy      <= active;
            err       <= (state == ABORT);
        end
    end

endmodule

// File: tb/tb_cascade_sequencer.sv
// Bench for cascade_sequencer: directed sequence table, timeout/reset corners, random pulses vs. a pulse-level model.
module tb_cascade_sequencer;

    localparam int TO = 8;

    logic       clk, rst_n, sp_en, sngl, mode_8080, inta;
    logic [7:0] icw3;
    logic [2:0] ack_ir, cas_in, cas_out;
    logic       cas_oe, sel_slave, code_en, busy, err;
    logic [1:0] byte_sel;

    int total = 0;
    int bad   = 0;

    cascade_sequencer #(.CAS_W(3), .TO_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .sp_en(sp_en), .sngl(sngl), .mode_8080(mode_8080),
        .icw3(icw3), .ack_ir(ack_ir), .inta(inta), .cas_in(cas_in),
        .cas_out(cas_out), .cas_oe(cas_oe), .sel_slave(sel_slave), .code_en(code_en),
        .byte_sel(byte_sel), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse-level reference: one step per clock, expectations lag the step by one cycle.
    typedef struct packed {
        logic [2:0] cas_out;
        logic       cas_oe, sel, code, busy, err;
        logic [1:0] bsel;
    } exp_t;

    exp_t       exp_o = '0;
    logic       m_prev = 0, m_active = 0, m_abort = 0, m_in_pulse = 0, m_sel = 0;
    logic       m_sp = 0, m_sngl = 0, m_8080 = 0;
    logic [7:0] m_icw3 = 0;
    logic [2:0] m_ack = 0;
    int         m_pulse = 0, m_gap = 0;

    function automatic exp_t model_out();
        exp_t e;
        logic casc, slave, drive;
        e = '0;
        if (m_abort) begin
            e.err = 1'b1;
        end else if (m_active) begin
            casc  = m_sp && !m_sngl && m_icw3[m_ack];
            slave = !m_sp && !m_sngl;
            e.busy    = 1'b1;
            e.cas_oe  = casc;
            e.cas_out = casc ? m_ack : 3'd0;
            e.sel     = m_sel;
            if (casc)       drive = m_8080 && m_pulse == 1;
            else if (slave) drive = m_sel && m_pulse >= 2;
            else            drive = m_8080 || m_pulse >= 2;
            e.code = m_in_pulse && drive;
            e.bsel = e.code ? 2'(m_pulse - 1) : 2'd0;
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic rise, fall;
        if (!rst_n) begin
            m_prev = 0; m_active = 0; m_abort = 0; m_in_pulse = 0; m_sel = 0;
            m_pulse = 0; m_gap = 0; exp_o = '0;
        end else begin
            exp_o = model_out();
            rise = inta && !m_prev;
            fall = !inta && m_prev;
            m_prev = inta;
            if (m_active) begin
                if (rise) begin
                    m_pulse++; m_in_pulse = 1; m_gap = 0;
                    if (m_pulse == 2) m_sel = !m_sp && !m_sngl && (cas_in == m_icw3[2:0]);
                end else if (fall && m_pulse == (m_8080 ? 3 : 2)) begin
                    m_active = 0; m_in_pulse = 0; m_sel = 0;
                end else begin
                    if (fall) m_in_pulse = 0;
`ifdef CASCADE_TIMEOUT_EN
                    if (!inta) begin
                        if (m_gap == TO) begin
                            m_active = 0; m_abort = 1; m_in_pulse = 0; m_sel = 0;
                        end else begin
                            m_gap++;
                        end
                    end
`endif
                end
            end else begin
                m_abort = 0;
                if (rise) begin
                    m_sp = sp_en; m_sngl = sngl; m_8080 = mode_8080; m_icw3 = icw3; m_ack = ack_ir;
                    m_active = 1; m_pulse = 1; m_in_pulse = 1; m_gap = 0; m_sel = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model.cas_out", cas_out, exp_o.cas_out);
            chk("model.cas_oe", cas_oe, exp_o.cas_oe);
            chk("model.sel_slave", sel_slave, exp_o.sel);
            chk("model.code_en", code_en, exp_o.code);
            chk("model.busy", busy, exp_o.busy);
            chk("model.err", err, exp_o.err);
            if (exp_o.code || !exp_o.busy) chk("model.byte_sel", byte_sel, exp_o.bsel);
        end
    end

    typedef struct {
        logic       sp_en, sngl, m8080;
        logic [7:0] icw3;
        logic [2:0] ack_ir, cas_in;
        logic       oe;
        logic [2:0] cas;
        logic       sel;
        logic [2:0] code;   // {p3,p2,p1}
        logic [5:0] bsel;   // {p3,p2,p1}, two bits each
    } vec_t;

    localparam int NV = 10;
    vec_t vt [NV];

    initial begin
        int np, errs, hi, lo;
        vt[0] = '{1'b1, 1'b0, 1'b0, 8'h09, 3'd3, 3'd0, 1'b1, 3'd3, 1'b0, 3'b000, 6'b000000};
        vt[1] = '{1'b1, 1'b0, 1'b0, 8'h09, 3'd2, 3'd0, 1'b0, 3'd0, 1'b0, 3'b010, 6'b000100};
        vt[2] = '{1'b0, 1'b0, 1'b0, 8'h07, 3'd0, 3'd7, 1'b0, 3'd0, 1'b1, 3'b010, 6'b000100};
        vt[3] = '{1'b0, 1'b0, 1'b0, 8'h01, 3'd0, 3'd7, 1'b0, 3'd0, 1'b0, 3'b000, 6'b000000};
        vt[4] = '{1'b1, 1'b0, 1'b1, 8'h01, 3'd0, 3'd0, 1'b1, 3'd0, 1'b0, 3'b001, 6'b000000};
        vt[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 3'b110, 6'b100100};
        vt[6] = '{1'b0, 1'b1, 1'b0, 8'h07, 3'd4, 3'd7, 1'b0, 3'd0, 1'b0, 3'b010, 6'b000100};
        vt[7] = '{1'b1, 1'b1, 1'b1, 8'hff, 3'd5, 3'd0, 1'b0, 3'd0, 1'b0, 3'b111, 6'b100100};
        vt[8] = '{1'b1, 1'b0, 1'b1, 8'h40, 3'd6, 3'd0, 1'b1, 3'd6, 1'b0, 3'b001, 6'b000000};
        vt[9] = '{1'b0, 1'b0, 1'b1, 8'h05, 3'd0, 3'd4, 1'b0, 3'd0, 1'b0, 3'b000, 6'b000000};

        rst_n = 0; sp_en = 0; sngl = 0; mode_8080 = 0; inta = 0;
        icw3 = 0; ack_ir = 0; cas_in = 0;
        #3;
        chk("reset.cas_out", cas_out, 0);
        chk("reset.cas_oe", cas_oe, 0);
        chk("reset.sel_slave", sel_slave, 0);
        chk("reset.code_en", code_en, 0);
        chk("reset.byte_sel", byte_sel, 0);
        chk("reset.busy", busy, 0);
        chk("reset.err", err, 0);
        #9 rst_n = 1;
        tick(2);

        // Directed sequences; configuration is scrambled after pulse 1 and must be ignored.
        for (int v = 0; v < NV; v++) begin
            sp_en = vt[v].sp_en; sngl = vt[v].sngl; mode_8080 = vt[v].m8080;
            icw3 = vt[v].icw3; ack_ir = vt[v].ack_ir; cas_in = vt[v].cas_in;
            np = vt[v].m8080 ? 3 : 2;
            for (int p = 1; p <= np; p++) begin
                inta = 1; tick(2);
                chk($sformatf("vec%0d.p%0d.code_en", v, p), code_en, vt[v].code[p-1]);
                if (vt[v].code[p-1])
                    chk($sformatf("vec%0d.p%0d.byte_sel", v, p), byte_sel, vt[v].bsel[2*p-1 -: 2]);
                chk($sformatf("vec%0d.p%0d.cas_oe", v, p), cas_oe, vt[v].oe);
                chk($sformatf("vec%0d.p%0d.cas_out", v, p), cas_out, vt[v].cas);
                chk($sformatf("vec%0d.p%0d.busy", v, p), busy, 1);
                if (p == np) chk($sformatf("vec%0d.sel_slave", v), sel_slave, vt[v].sel);
                if (p == 1) begin
                    sp_en = !sp_en; sngl = !sngl; mode_8080 = !mode_8080;
                    icw3 = ~icw3; ack_ir = ~ack_ir;
                end
                tick(1); inta = 0; tick(3);
            end
            tick(1);
            chk($sformatf("vec%0d.end.busy", v), busy, 0);
            chk($sformatf("vec%0d.end.cas_oe", v), cas_oe, 0);
        end

        // Inter-pulse gap: exactly TO idle samples is tolerated, TO+1 aborts when the timeout is built in.
        sp_en = 1; sngl = 0; mode_8080 = 0; icw3 = 8'h00; ack_ir = 0;
        inta = 1; tick(2); inta = 0; tick(TO);
        inta = 1; tick(2);
        chk("gap_ok.code_en", code_en, 1);
        chk("gap_ok.byte_sel", byte_sel, 1);
        tick(1); inta = 0; tick(3);
        chk("gap_ok.busy", busy, 0);

        inta = 1; tick(2); inta = 0;
        errs = 0;
        repeat (TO + 6) begin
            tick(1);
            if (err) errs++;
        end
`ifdef CASCADE_TIMEOUT_EN
        chk("timeout.err_pulses", errs, 1);
        chk("timeout.busy", busy, 0);
        chk("timeout.cas_oe", cas_oe, 0);
        chk("timeout.code_en", code_en, 0);
`else
        chk("no_timeout.err_pulses", errs, 0);
        chk("no_timeout.busy", busy, 1);
        inta = 1; tick(2); inta = 0; tick(3);
        chk("no_timeout.end.busy", busy, 0);
`endif

        // Asynchronous reset during pulse 2 of a cascaded 8080 sequence.
        sp_en = 1; sngl = 0; mode_8080 = 1; icw3 = 8'h10; ack_ir = 3'd4;
        inta = 1; tick(3); inta = 0; tick(3);
        inta = 1; tick(2);
        chk("arst.pre.cas_oe", cas_oe, 1);
        chk("arst.pre.busy", busy, 1);
        chk("arst.pre.cas_out", cas_out, 4);
        #2 rst_n = 0;
        #1;
        chk("arst.cas_oe", cas_oe, 0);
        chk("arst.code_en", code_en, 0);
        chk("arst.busy", busy, 0);
        chk("arst.cas_out", cas_out, 0);
        inta = 0;
        #2 rst_n = 1;
        tick(1);
        inta = 1; tick(2);
        chk("arst.fresh.code_en", code_en, 1);
        chk("arst.fresh.byte_sel", byte_sel, 0);
        chk("arst.fresh.cas_oe", cas_oe, 1);
        tick(1); inta = 0; tick(3);
        repeat (2) begin
            inta = 1; tick(3); inta = 0; tick(3);
        end
        tick(1);
        chk("arst.end.busy", busy, 0);

        // Random pulse trains with configuration churn, checked cycle by cycle against the model.
        for (int i = 0; i < 300; i++) begin
            sp_en = 1'($urandom_range(0, 1));
            sngl = ($urandom_range(0, 3) == 0);
            mode_8080 = 1'($urandom_range(0, 1));
            icw3 = 8'($urandom);
            ack_ir = 3'($urandom_range(0, 7));
            cas_in = $urandom_range(0, 1) ? icw3[2:0] : 3'($urandom_range(0, 7));
            hi = $urandom_range(1, 3);
            lo = $urandom_range(1, 12);
            inta = 1; tick(hi);
            inta = 0; tick(lo);
        end
        tick(TO + 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
